// File: rtl/sap1_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sap1_ctrl_pkg
// Shared types for the SAP-1 control sequencer: opcode and T-state encodings,
// the packed control word carrying every datapath strobe, and the idle word.
// -----------------------------------------------------------------------------
package sap1_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_LDA = 4'b0000,
    OP_ADD = 4'b0001,
    OP_SUB = 4'b0010,
    OP_JMP = 4'b0100,
    OP_JC  = 4'b0101,
    OP_JZ  = 4'b0110,
    OP_OUT = 4'b1110,
    OP_HLT = 4'b1111
  } opcode_e;

  // Encoding doubles as the externally visible tstate value.
  typedef enum logic [2:0] {
    TS_T0   = 3'd0,
    TS_T1   = 3'd1,
    TS_T2   = 3'd2,
    TS_T3   = 3'd3,
    TS_T4   = 3'd4,
    TS_HALT = 3'd7
  } tstate_e;

  typedef struct packed {
    logic pc_out;
    logic pc_inc;
    logic pc_load;
    logic mar_load;
    logic ram_out;
    logic ir_load;
    logic ir_out;
    logic a_load;
    logic a_out;
    logic b_load;
    logic alu_out;
    logic alu_sum;
    logic alu_sub;
    logic flags_load;
    logic out_load;
  } ctrl_word_t;

  localparam ctrl_word_t CW_IDLE = '0;

  // T-state holding the final micro-op of each instruction (HLT excluded).
  function automatic tstate_e last_tstate(input logic [3:0] op);
    case (op)
      OP_LDA:          return TS_T3;
      OP_ADD, OP_SUB:  return TS_T4;
      default:         return TS_T2;
    endcase
  endfunction

endpackage

// File: rtl/sap1_controller_decoder.sv
// -----------------------------------------------------------------------------
// sap1_decoder
// Combinational microcode table: (T-state, opcode, flags) -> control word.
// Ports:
//   i_tstate      current T-state
//   i_opcode      4-bit opcode nibble
//   i_carry_flag  registered carry flag (JC)
//   i_zero_flag   registered zero flag (JZ)
//   o_cw          control word for this cycle (ungated)
//   o_last        this cycle is the final cycle of the instruction
//   o_halt        HLT reached T2; sequencer must enter HALT
// -----------------------------------------------------------------------------
import sap1_ctrl_pkg::*;

module sap1_decoder #(
  parameter bit EARLY_END = 1'b1
) (
  input  tstate_e    i_tstate,
  input  logic [3:0] i_opcode,
  input  logic       i_carry_flag,
  input  logic       i_zero_flag,
  output ctrl_word_t o_cw,
  output logic       o_last,
  output logic       o_halt
);

  always_comb begin
    o_cw   = CW_IDLE;
    o_last = 1'b0;
    o_halt = 1'b0;

    case (i_tstate)
      TS_T0: begin
        o_cw.pc_out   = 1'b1;
        o_cw.mar_load = 1'b1;
      end
      TS_T1: begin
        o_cw.ram_out = 1'b1;
        o_cw.ir_load = 1'b1;
        o_cw.pc_inc  = 1'b1;
      end
      TS_T2: begin
        case (i_opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            o_cw.ir_out   = 1'b1;
            o_cw.mar_load = 1'b1;
          end
          OP_JMP: begin
            o_cw.ir_out  = 1'b1;
            o_cw.pc_load = 1'b1;
          end
          // Untaken conditional jumps leave the bus undriven as well.
          OP_JC: begin
            o_cw.ir_out  = i_carry_flag;
            o_cw.pc_load = i_carry_flag;
          end
          OP_JZ: begin
            o_cw.ir_out  = i_zero_flag;
            o_cw.pc_load = i_zero_flag;
          end
          OP_OUT: begin
            o_cw.a_out    = 1'b1;
            o_cw.out_load = 1'b1;
          end
          OP_HLT:  o_halt = 1'b1;
          default: ;
        endcase
      end
      TS_T3: begin
        case (i_opcode)
          OP_LDA: begin
            o_cw.ram_out = 1'b1;
            o_cw.a_load  = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            o_cw.ram_out = 1'b1;
            o_cw.b_load  = 1'b1;
          end
          default: ;
        endcase
      end
      TS_T4: begin
        if (i_opcode == OP_ADD || i_opcode == OP_SUB) begin
          o_cw.alu_out    = 1'b1;
          o_cw.a_load     = 1'b1;
          o_cw.flags_load = 1'b1;
          o_cw.alu_sum    = (i_opcode == OP_ADD);
          o_cw.alu_sub    = (i_opcode == OP_SUB);
        end
      end
      default: ;
    endcase

    // HLT never completes; it leaves through HALT instead of T0.
    if (i_opcode != OP_HLT) begin
      if (EARLY_END)
        o_last = (i_tstate == last_tstate(i_opcode));
      else
        o_last = (i_tstate == TS_T4);
    end
  end

endmodule

// File: rtl/sap1_controller.sv
// -----------------------------------------------------------------------------
// sap1_controller
// SAP-1 control sequencer: T-state register, step gating and HALT handling
// around the microcode decoder.
//
//   state   | meaning
//   --------+------------------------------------------------
//   T0      | fetch: PC -> MAR
//   T1      | fetch: RAM -> IR, PC increment
//   T2..T4  | execute micro-ops (opcode dependent)
//   HALT    | sticky stop, all strobes low; only reset leaves
//
// Ports:
//   clk, rst (async, active low), step_en (advance gate)
//   opcode, carry_flag, zero_flag   inputs from IR / flag register
//   pc_*, mar_load, ram_out, ir_*, a_*, b_load, alu_*, flags_load, out_load
//                                    datapath strobes
//   halted, tstate, instr_done       status
// -----------------------------------------------------------------------------
import sap1_ctrl_pkg::*;

module sap1_controller #(
  parameter int OPCODE_W  = 4,
  parameter bit EARLY_END = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                step_en,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                carry_flag,
  input  logic                zero_flag,
  output logic                pc_out,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                mar_load,
  output logic                ram_out,
  output logic                ir_load,
  output logic                ir_out,
  output logic                a_load,
  output logic                a_out,
  output logic                b_load,
  output logic                alu_out,
  output logic                alu_sum,
  output logic                alu_sub,
  output logic                flags_load,
  output logic                out_load,
  output logic                halted,
  output logic [2:0]          tstate,
  output logic                instr_done
);

  tstate_e    r_state;
  tstate_e    w_state_nxt;
  ctrl_word_t w_cw_dec;
  ctrl_word_t w_cw;
  logic       w_last;
  logic       w_halt;
  logic       w_active;
  logic [3:0] w_op;

  generate
    if (OPCODE_W >= 4) begin : g_op_trunc
      assign w_op = opcode[3:0];
    end else begin : g_op_ext
      assign w_op = {{(4-OPCODE_W){1'b0}}, opcode};
    end
  endgenerate

  sap1_decoder #(
    .EARLY_END (EARLY_END)
  ) u_decoder (
    .i_tstate     (r_state),
    .i_opcode     (w_op),
    .i_carry_flag (carry_flag),
    .i_zero_flag  (zero_flag),
    .o_cw         (w_cw_dec),
    .o_last       (w_last),
    .o_halt       (w_halt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= TS_T0;
    else      r_state <= w_state_nxt;
  end

  // Strobes are also held low while rst is asserted, since the state already
  // sits at T0 and would otherwise present the fetch word during reset.
  assign w_active = rst & step_en & (r_state != TS_HALT);

  always_comb begin
    w_state_nxt = r_state;
    w_cw        = CW_IDLE;
    instr_done  = 1'b0;

    if (w_active) begin
      w_cw       = w_cw_dec;
      instr_done = w_last;
    end

    if (step_en && r_state != TS_HALT) begin
      if (w_halt)      w_state_nxt = TS_HALT;
      else if (w_last) w_state_nxt = TS_T0;
      else begin
        case (r_state)
          TS_T0:   w_state_nxt = TS_T1;
          TS_T1:   w_state_nxt = TS_T2;
          TS_T2:   w_state_nxt = TS_T3;
          TS_T3:   w_state_nxt = TS_T4;
          default: w_state_nxt = TS_T0;
        endcase
      end
    end
  end

  assign pc_out     = w_cw.pc_out;
  assign pc_inc     = w_cw.pc_inc;
  assign pc_load    = w_cw.pc_load;
  assign mar_load   = w_cw.mar_load;
  assign ram_out    = w_cw.ram_out;
  assign ir_load    = w_cw.ir_load;
  assign ir_out     = w_cw.ir_out;
  assign a_load     = w_cw.a_load;
  assign a_out      = w_cw.a_out;
  assign b_load     = w_cw.b_load;
  assign alu_out    = w_cw.alu_out;
  assign alu_sum    = w_cw.alu_sum;
  assign alu_sub    = w_cw.alu_sub;
  assign flags_load = w_cw.flags_load;
  assign out_load   = w_cw.out_load;

  assign halted = rst & (r_state == TS_HALT);
  assign tstate = r_state;

endmodule

// File: tb/tb_sap1_controller.sv
// -----------------------------------------------------------------------------
// tb_sap1_controller
// Directed bench for sap1_controller. Two instances share all inputs:
// dut1 with EARLY_END=1 and dut0 with EARLY_END=0. Expected cycle records are
// queued as stimulus is applied and popped when the outputs are sampled.
// -----------------------------------------------------------------------------
module tb_sap1_controller;

  // Control word bit order used throughout the bench.
  localparam logic [14:0] PC_OUT     = 15'h4000;
  localparam logic [14:0] PC_INC     = 15'h2000;
  localparam logic [14:0] PC_LOAD    = 15'h1000;
  localparam logic [14:0] MAR_LOAD   = 15'h0800;
  localparam logic [14:0] RAM_OUT    = 15'h0400;
  localparam logic [14:0] IR_LOAD    = 15'h0200;
  localparam logic [14:0] IR_OUT     = 15'h0100;
  localparam logic [14:0] A_LOAD     = 15'h0080;
  localparam logic [14:0] A_OUT      = 15'h0040;
  localparam logic [14:0] B_LOAD     = 15'h0020;
  localparam logic [14:0] ALU_OUT    = 15'h0010;
  localparam logic [14:0] ALU_SUM    = 15'h0008;
  localparam logic [14:0] ALU_SUB    = 15'h0004;
  localparam logic [14:0] FLAGS_LOAD = 15'h0002;
  localparam logic [14:0] OUT_LOAD   = 15'h0001;
  localparam logic [14:0] BUS_DRV    = PC_OUT | RAM_OUT | IR_OUT | A_OUT | ALU_OUT;
  localparam logic [14:0] NONE       = 15'h0000;

  logic       clk = 1'b0;
  logic       rst;
  logic       step_en;
  logic [3:0] opcode;
  logic       carry_flag;
  logic       zero_flag;

  logic [14:0] cw1, cw0;
  logic        hl1, hl0, done1, done0;
  logic [2:0]  ts1, ts0;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        sel;
    logic [14:0] cw;
    logic        done;
    logic        done_chk;
    logic        hl;
    logic [2:0]  ts;
    string       tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  sap1_controller #(.OPCODE_W(4), .EARLY_END(1'b1)) dut1 (
    .clk(clk), .rst(rst), .step_en(step_en), .opcode(opcode),
    .carry_flag(carry_flag), .zero_flag(zero_flag),
    .pc_out(cw1[14]), .pc_inc(cw1[13]), .pc_load(cw1[12]), .mar_load(cw1[11]),
    .ram_out(cw1[10]), .ir_load(cw1[9]), .ir_out(cw1[8]), .a_load(cw1[7]),
    .a_out(cw1[6]), .b_load(cw1[5]), .alu_out(cw1[4]), .alu_sum(cw1[3]),
    .alu_sub(cw1[2]), .flags_load(cw1[1]), .out_load(cw1[0]),
    .halted(hl1), .tstate(ts1), .instr_done(done1)
  );

  sap1_controller #(.OPCODE_W(4), .EARLY_END(1'b0)) dut0 (
    .clk(clk), .rst(rst), .step_en(step_en), .opcode(opcode),
    .carry_flag(carry_flag), .zero_flag(zero_flag),
    .pc_out(cw0[14]), .pc_inc(cw0[13]), .pc_load(cw0[12]), .mar_load(cw0[11]),
    .ram_out(cw0[10]), .ir_load(cw0[9]), .ir_out(cw0[8]), .a_load(cw0[7]),
    .a_out(cw0[6]), .b_load(cw0[5]), .alu_out(cw0[4]), .alu_sum(cw0[3]),
    .alu_sub(cw0[2]), .flags_load(cw0[1]), .out_load(cw0[0]),
    .halted(hl0), .tstate(ts0), .instr_done(done0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_front();
    exp_t        e;
    logic [14:0] ocw;
    logic        odone, ohl;
    logic [2:0]  ots;
    e = sb.pop_front();
    if (e.sel) begin
      ocw = cw1; odone = done1; ohl = hl1; ots = ts1;
    end else begin
      ocw = cw0; odone = done0; ohl = hl0; ots = ts0;
    end
    chk({e.tag, "/cw"},     32'(ocw), 32'(e.cw));
    chk({e.tag, "/tstate"}, 32'(ots), 32'(e.ts));
    chk({e.tag, "/halted"}, 32'(ohl), 32'(e.hl));
    if (e.done_chk) chk({e.tag, "/instr_done"}, 32'(odone), 32'(e.done));
    chk({e.tag, "/sum_and_sub"},  32'(ocw[3] & ocw[2]), 32'd0);
    chk({e.tag, "/flags_no_alu"}, 32'(ocw[1] & ~ocw[4]), 32'd0);
    chk({e.tag, "/bus_conflict"}, 32'($countones(ocw & BUS_DRV) > 1), 32'd0);
  endtask

  // Queue the expected record, sample 1 time unit after the falling edge
  // (inputs change exactly on that edge), then move to the next falling edge.
  task automatic cyc(input logic sel, input logic [14:0] cw, input logic done,
                     input logic [2:0] ts, input logic hl, input string tag,
                     input logic done_chk);
    exp_t e;
    e.sel = sel; e.cw = cw; e.done = done; e.done_chk = done_chk;
    e.hl = hl; e.ts = ts; e.tag = tag;
    sb.push_back(e);
    #1;
    check_front();
    @(negedge clk);
  endtask

  task automatic fetch(input logic sel, input string tag);
    cyc(sel, PC_OUT | MAR_LOAD,          1'b0, 3'd0, 1'b0, {tag, "_t0"}, 1'b1);
    cyc(sel, RAM_OUT | IR_LOAD | PC_INC, 1'b0, 3'd1, 1'b0, {tag, "_t1"}, 1'b1);
  endtask

  initial begin
    rst = 1'b1; step_en = 1'b1; opcode = 4'b0001;
    carry_flag = 1'b0; zero_flag = 1'b0;
    #1 rst = 1'b0;
    @(negedge clk);
    cyc(1'b1, NONE, 1'b0, 3'd0, 1'b0, "reset_a", 1'b1);
    cyc(1'b0, NONE, 1'b0, 3'd0, 1'b0, "reset_b", 1'b1);
    rst = 1'b1;

    // ADD interrupted by reset at T3
    fetch(1'b1, "add_int");
    cyc(1'b1, IR_OUT | MAR_LOAD, 1'b0, 3'd2, 1'b0, "add_int_t2", 1'b1);
    rst = 1'b0;
    cyc(1'b1, NONE, 1'b0, 3'd0, 1'b0, "rst_mid_add", 1'b1);
    rst = 1'b1;

    // ADD complete
    fetch(1'b1, "add");
    cyc(1'b1, IR_OUT | MAR_LOAD, 1'b0, 3'd2, 1'b0, "add_t2", 1'b1);
    cyc(1'b1, RAM_OUT | B_LOAD,  1'b0, 3'd3, 1'b0, "add_t3", 1'b1);
    cyc(1'b1, ALU_OUT | ALU_SUM | A_LOAD | FLAGS_LOAD, 1'b1, 3'd4, 1'b0, "add_t4", 1'b1);

    // SUB
    opcode = 4'b0010;
    fetch(1'b1, "sub");
    cyc(1'b1, IR_OUT | MAR_LOAD, 1'b0, 3'd2, 1'b0, "sub_t2", 1'b1);
    cyc(1'b1, RAM_OUT | B_LOAD,  1'b0, 3'd3, 1'b0, "sub_t3", 1'b1);
    cyc(1'b1, ALU_OUT | ALU_SUB | A_LOAD | FLAGS_LOAD, 1'b1, 3'd4, 1'b0, "sub_t4", 1'b1);

    // JZ not taken, then taken
    opcode = 4'b0110; zero_flag = 1'b0;
    fetch(1'b1, "jz_nt");
    cyc(1'b1, NONE, 1'b1, 3'd2, 1'b0, "jz_nt_t2", 1'b1);
    zero_flag = 1'b1;
    fetch(1'b1, "jz_tk");
    cyc(1'b1, IR_OUT | PC_LOAD, 1'b1, 3'd2, 1'b0, "jz_tk_t2", 1'b1);
    zero_flag = 1'b0;

    // JC taken, then not taken
    opcode = 4'b0101; carry_flag = 1'b1;
    fetch(1'b1, "jc_tk");
    cyc(1'b1, IR_OUT | PC_LOAD, 1'b1, 3'd2, 1'b0, "jc_tk_t2", 1'b1);
    carry_flag = 1'b0;
    fetch(1'b1, "jc_nt");
    cyc(1'b1, NONE, 1'b1, 3'd2, 1'b0, "jc_nt_t2", 1'b1);

    // LDA with a two-cycle stall at T2
    opcode = 4'b0000;
    fetch(1'b1, "lda");
    step_en = 1'b0;
    cyc(1'b1, NONE, 1'b0, 3'd2, 1'b0, "lda_stall0", 1'b1);
    cyc(1'b1, NONE, 1'b0, 3'd2, 1'b0, "lda_stall1", 1'b1);
    step_en = 1'b1;
    cyc(1'b1, IR_OUT | MAR_LOAD, 1'b0, 3'd2, 1'b0, "lda_t2", 1'b1);
    cyc(1'b1, RAM_OUT | A_LOAD,  1'b1, 3'd3, 1'b0, "lda_t3", 1'b1);

    // OUT and JMP
    opcode = 4'b1110;
    fetch(1'b1, "out");
    cyc(1'b1, A_OUT | OUT_LOAD, 1'b1, 3'd2, 1'b0, "out_t2", 1'b1);
    opcode = 4'b0100;
    fetch(1'b1, "jmp");
    cyc(1'b1, IR_OUT | PC_LOAD, 1'b1, 3'd2, 1'b0, "jmp_t2", 1'b1);

    // HLT then 20 idle clocks in HALT, then reset out
    opcode = 4'b1111;
    fetch(1'b1, "hlt");
    cyc(1'b1, NONE, 1'b0, 3'd2, 1'b0, "hlt_t2", 1'b0);
    for (int i = 0; i < 20; i++)
      cyc(1'b1, NONE, 1'b0, 3'd7, 1'b1, "halt", 1'b1);
    rst = 1'b0;
    cyc(1'b1, NONE, 1'b0, 3'd0, 1'b0, "halt_rst", 1'b1);
    rst = 1'b1;

    // Undefined opcode on the full-length instance
    opcode = 4'b1010;
    fetch(1'b0, "nop_full");
    cyc(1'b0, NONE, 1'b0, 3'd2, 1'b0, "nop_full_t2", 1'b1);
    cyc(1'b0, NONE, 1'b0, 3'd3, 1'b0, "nop_full_t3", 1'b1);
    cyc(1'b0, NONE, 1'b1, 3'd4, 1'b0, "nop_full_t4", 1'b1);
    cyc(1'b0, PC_OUT | MAR_LOAD, 1'b0, 3'd0, 1'b0, "nop_full_next", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
